// File: rtl/xor_share_ctrl_if.sv
// Bundle of request/operand/grant/result signals shared by xor_share_ctrl.
// The op_cnt signal exists only when XOR_SHARE_CNT_EN is defined.
interface xor_share_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic [3:0]         req;
  logic [4*WIDTH-1:0] a_bus;
  logic [4*WIDTH-1:0] b_bus;
  logic [3:0]         gnt;
  logic [3:0]         done;
  logic [WIDTH-1:0]   x_out;
  logic               busy;
`ifdef XOR_SHARE_CNT_EN
  logic [15:0]        op_cnt;
`endif

  // Requester side: drives requests and operands, observes grant and result
  modport master (
    output req, a_bus, b_bus,
    input  gnt, done, x_out, busy
`ifdef XOR_SHARE_CNT_EN
    , input op_cnt
`endif
  );

  // Controller side
  modport slave (
    input  req, a_bus, b_bus,
    output gnt, done, x_out, busy
`ifdef XOR_SHARE_CNT_EN
    , output op_cnt
`endif
  );
endinterface

// File: rtl/xor_share_ctrl.sv
// xor_share_ctrl: one WIDTH-bit XOR datapath shared by four requesters.
// Round-robin arbitration in IDLE, operands latched at grant, result
// registered in EXEC, one-cycle done pulse issued from RESP, grant held in
// RELEASE until the winner drops its request.
// Optional feature: define XOR_SHARE_CNT_EN to add the saturating 16-bit
// completed-operation counter (op_cnt).
module xor_share_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  xor_share_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [1:0]       ptr_q;     // first requester examined by the next search
  logic [3:0]       gnt_q;
  logic [3:0]       done_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] x_q;

  logic             found;
  logic [1:0]       cand;
  logic [1:0]       win_idx;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;

  logic             grant_ld;
  logic             result_ld;
  logic             done_set;
  logic             gnt_clr;

  // Round-robin search: first active request at or after ptr_q, wrapping 3->0
  always_comb begin
    found   = 1'b0;
    cand    = ptr_q;
    win_idx = ptr_q;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && bus.req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Operand selection for the search winner
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (win_idx == 2'(i)) begin
        a_sel = bus.a_bus[i*WIDTH +: WIDTH];
        b_sel = bus.b_bus[i*WIDTH +: WIDTH];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state and datapath control strobes
  always_comb begin
    state_d   = state_q;
    grant_ld  = 1'b0;
    result_ld = 1'b0;
    done_set  = 1'b0;
    gnt_clr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_ld = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        result_ld = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        done_set = 1'b1;
        state_d  = RELEASE;
      end
      RELEASE: begin
        if ((bus.req & gnt_q) == 4'b0000) begin
          gnt_clr = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant, operand latches, result and done pulse; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      gnt_q  <= '0;
      done_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      x_q    <= '0;
    end else begin
      done_q <= '0;
      if (grant_ld) begin
        gnt_q <= 4'b0001 << win_idx;
        a_q   <= a_sel;
        b_q   <= b_sel;
        ptr_q <= win_idx + 2'd1;
      end
      if (result_ld) begin
        x_q <= a_q ^ b_q;
      end
      if (done_set) begin
        done_q <= gnt_q;
      end
      if (gnt_clr) begin
        gnt_q <= '0;
      end
    end
  end

`ifdef XOR_SHARE_CNT_EN
  logic [15:0] cnt_q;

  // Completed-operation counter, one step per RESP cycle, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == RESP && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.op_cnt = cnt_q;
`endif

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.x_out = x_q;
  assign bus.busy  = (state_q != IDLE);

endmodule
